ks10_mem_responder: RTL

- Bus-side memory responder; the target end of the CPU memory/IO bus request/acknowledge protocol.
- Decodes CPU address/flag words, runs a synchronous single-port memory access with programmable wait states, then returns ACK and read data.
- Non-selected requests get no ACK, so the CPU's NXM logic times out normally.
- Sits between the bus arbiter output and the external SSRAM/block-RAM controller.

---
 rtl/ks10_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ks10_mem_responder.sv
// rtl/ks10_mem_responder.sv - KS10 bus memory responder: decode, single-port access, wait states, ACK
// Optional memory parity (bit 36, even) is enabled by defining KS10_MEM_PARITY_EN.
module ks10_mem_responder #(
  parameter int ADDR_WIDTH  = 20,
  parameter int BASE        = 0,
  parameter int SIZE        = 1 << 20,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busREQI,
  input  logic [0:35]           busADDRI,
  input  logic [0:35]           busDATAI,
  output logic                  busACKO,
  output logic [0:35]           busDATAO,
  output logic                  busBUSY,
  output logic [ADDR_WIDTH-1:0] memADDR,
  output logic                  memRD,
  output logic                  memWR,
`ifdef KS10_MEM_PARITY_EN
  output logic [36:0]           memDOUT,
  input  logic [36:0]           memDIN,
  output logic                  memPERR
`else
  output logic [35:0]           memDOUT,
  input  logic [35:0]           memDIN
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RDWAIT = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_ACK    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
  // Window end is clipped to the top of the 22-bit physical space instead of wrapping.
  localparam logic [31:0] WIN_END   = 32'(BASE) + 32'(SIZE);
  localparam logic [23:0] WIN_LO    = 24'(BASE);
  localparam logic [23:0] WIN_HI    = (WIN_END > 32'h0040_0000) ? 24'h40_0000 : WIN_END[23:0];

  logic [2:0]  state;
  logic [3:0]  wait_cnt;
  logic        rd_flag;
  logic        wr_flag;
  logic [35:0] wdata;
  logic [35:0] rdata;
  logic [23:0] req_addr;
  logic        lo_ok;
  logic        hi_ok;
  logic        sel;
  logic        unused_flags;

  assign req_addr = {2'b00, busADDRI[14:35]};
  assign lo_ok    = (req_addr + 24'd1) > WIN_LO;
  assign hi_ok    = req_addr < WIN_HI;
  assign sel      = busREQI && !busADDRI[10] && (busADDRI[3] || busADDRI[5]) && lo_ok && hi_ok;

  assign unused_flags = ^{busADDRI[0:2], busADDRI[4], busADDRI[6:9], busADDRI[11:13]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      rd_flag  <= 1'b0;
      wr_flag  <= 1'b0;
      memADDR  <= '0;
      wdata    <= 36'd0;
      rdata    <= 36'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel) begin
            memADDR <= busADDRI[36-ADDR_WIDTH:35];
            rd_flag <= busADDRI[3];
            wr_flag <= busADDRI[5];
            wdata   <= busDATAI;
            state   <= busADDRI[3] ? ST_RD : ST_WR;
          end
        end
        ST_RD: state <= ST_RDWAIT;
        ST_RDWAIT: begin
          rdata <= memDIN[35:0];
          // Exchange: old contents are held in rdata while the new word is written.
          if (wr_flag) begin
            state <= ST_WR;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ST_WR: begin
          state    <= ST_WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: state <= ST_DONE;
        ST_DONE: begin
          // A request still held high after ACK must not be serviced twice.
          if (!busREQI) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign memRD    = (state == ST_RD);
  assign memWR    = (state == ST_WR);
  assign busACKO  = (state == ST_ACK);
  assign busBUSY  = (state != ST_IDLE);
  assign busDATAO = (busACKO && rd_flag) ? rdata : 36'd0;

`ifdef KS10_MEM_PARITY_EN
  assign memDOUT = {^wdata, wdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memPERR <= 1'b0;
    end else if (state == ST_RDWAIT && (memDIN[36] != ^memDIN[35:0])) begin
      memPERR <= 1'b1;
    end
  end
`else
  assign memDOUT = wdata;
`endif

endmodule
